// File: rtl/branch_pkg.sv
// Shared branch-prediction types: saturating counter encoding, PHT FSM states,
// and the global history width shared with the history shift register.
package branch_pkg;
  localparam int PHT_IDX_W = 8;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  typedef enum logic {INIT, RUN} pht_state_e;
endpackage

// File: rtl/sat_ctr2.sv
// 2-bit saturating counter next-value function; shared by any counter table.
module sat_ctr2
  import branch_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t nxt
);
  always_comb begin
    nxt = ctr;
    if (taken && ctr != CTR_ST)
      nxt = ctr + 2'd1;
    else if (!taken && ctr != CTR_SNT)
      nxt = ctr - 2'd1;
  end
endmodule

// File: rtl/gshare_pht.sv
// gshare pattern history table: PC^history indexed 2-bit counters with a
// registered prediction port, an execute-stage training port and an init sweep.
module gshare_pht
  import branch_pkg::*;
#(
  parameter int   IDX_W    = PHT_IDX_W,
  parameter ctr_t CTR_INIT = CTR_WNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_req,
  input  logic [31:0]      pred_pc,
  input  logic [IDX_W-1:0] ghr,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_en,
  input  logic [31:0]      upd_pc,
  input  logic [IDX_W-1:0] upd_ghr,
  input  logic             upd_taken,
  output logic             ready
);
  localparam int DEPTH = 2**IDX_W;

  pht_state_e       state;
  logic [IDX_W-1:0] sweep_cnt;
  ctr_t             ctr_q [DEPTH];

  logic [IDX_W-1:0] rd_idx, upd_idx, wr_idx;
  ctr_t             upd_nxt, wr_val;
  logic             wr_en;

  assign rd_idx  = pred_pc[IDX_W+1:2] ^ ghr;
  assign upd_idx = upd_pc[IDX_W+1:2] ^ upd_ghr;

  // PC bits outside the index window carry no information for this table
  logic unused_pc;
  assign unused_pc = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                       upd_pc[31:IDX_W+2], upd_pc[1:0]};

  sat_ctr2 u_sat (
    .ctr   (ctr_q[upd_idx]),
    .taken (upd_taken),
    .nxt   (upd_nxt)
  );

  // Single write port: the sweep owns it in INIT, training owns it in RUN
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = sweep_cnt;
    wr_val = CTR_INIT;
    if (!rst) begin
      if (state == INIT) begin
        wr_en = 1'b1;
      end else if (upd_en) begin
        wr_en  = 1'b1;
        wr_idx = upd_idx;
        wr_val = upd_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ctr_q[wr_idx] <= wr_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      sweep_cnt  <= '0;
      ready      <= 1'b0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
    end else begin
      case (state)
        INIT: begin
          pred_valid <= 1'b0;
          sweep_cnt  <= sweep_cnt + 1'b1;
          if (sweep_cnt == IDX_W'(DEPTH-1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          // Read sees the pre-write value on a same-index collision
          pred_valid <= pred_req;
          if (pred_req) begin
            pred_taken <= ctr_q[rd_idx][1];
            pred_idx   <= rd_idx;
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_gshare_pht.sv
// Scoreboard bench for gshare_pht: expected predictions come from a bench-side
// counter model and are queued at request time, then checked as outputs appear.
module tb_gshare_pht;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pred_req = 1'b0;
  logic [31:0] pred_pc = '0;
  logic [7:0]  ghr = '0;
  logic        pred_valid, pred_taken;
  logic [7:0]  pred_idx;
  logic        upd_en = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [7:0]  upd_ghr = '0;
  logic        upd_taken = 1'b0;
  logic        ready;

  gshare_pht dut (
    .clk(clk), .rst(rst),
    .pred_req(pred_req), .pred_pc(pred_pc), .ghr(ghr),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
    .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] idx;
    logic       tk;
  } exp_t;

  exp_t       sb [$];
  exp_t       mon_e;
  logic [1:0] mdl [256];
  logic       run = 1'b0;
  int         vecs = 0;
  int         errs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // One clock: drive, queue expected read (pre-update), train model, advance
  task automatic cyc(input logic pr, input logic [31:0] pc, input logic [7:0] g,
                     input logic ue, input logic [31:0] upc, input logic [7:0] ug,
                     input logic ut);
    logic [7:0] pi, ui;
    pred_req = pr; pred_pc = pc; ghr = g;
    upd_en = ue; upd_pc = upc; upd_ghr = ug; upd_taken = ut;
    pi = pc[9:2] ^ g;
    ui = upc[9:2] ^ ug;
    if (run && pr && !rst) sb.push_back('{pi, mdl[pi][1]});
    if (run && ue && !rst) mdl[ui] = sat(mdl[ui], ut);
    @(posedge clk); #1;
    pred_req = 1'b0;
    upd_en   = 1'b0;
  endtask

  task automatic pred(input logic [31:0] pc, input logic [7:0] g);
    cyc(1'b1, pc, g, 1'b0, 32'h0, 8'h0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [7:0] g, input logic t);
    cyc(1'b0, 32'h0, 8'h0, 1'b1, pc, g, t);
  endtask

  // Reset for n cycles (fetch keeps requesting), then time the sweep
  task automatic do_reset(input int n, input string tag);
    int nz;
    run = 1'b0;
    rst = 1'b1;
    pred_req = 1'b1; pred_pc = 32'h100; upd_en = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    pred_req = 1'b0; upd_en = 1'b0;
    chk({tag, "_rst_vld"}, pred_valid, 0);
    chk({tag, "_rst_rdy"}, ready, 0);
    chk({tag, "_rst_tk"}, pred_taken, 0);
    chk({tag, "_rst_idx"}, pred_idx, 0);
    rst = 1'b0;
    nz = 0;
    for (int i = 0; i < 256; i++) begin
      if (ready !== 1'b0) nz++;
      if (i == 5) begin
        cyc(1'b1, 32'h100, 8'h0, 1'b1, 32'h100, 8'h0, 1'b1);
        chk({tag, "_init_vld"}, pred_valid, 0);
      end else begin
        cyc(1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 8'h0, 1'b0);
      end
    end
    chk({tag, "_init_rdy_lo"}, nz, 0);
    chk({tag, "_init_rdy_hi"}, ready, 1);
    for (int i = 0; i < 256; i++) mdl[i] = 2'b01;
    run = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (pred_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexp_vld", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_idx", pred_idx, mon_e.idx);
        chk("sb_tk", pred_taken, mon_e.tk);
      end
    end
  end

  initial begin
    do_reset(2, "por");

    // First lookup after init: weakly not-taken
    pred(32'h100, 8'h00);
    chk("first_idx", pred_idx, 8'h40);
    chk("first_tk", pred_taken, 0);

    // Saturation up, then down to floor
    for (int i = 0; i < 5; i++) begin
      upd(32'h100, 8'h00, 1'b1);
      pred(32'h100, 8'h00);
    end
    upd(32'h100, 8'h00, 1'b0);
    pred(32'h100, 8'h00);
    chk("sat_hi_nt", pred_taken, 1);
    for (int i = 0; i < 4; i++) begin
      upd(32'h100, 8'h00, 1'b0);
      pred(32'h100, 8'h00);
    end
    chk("sat_lo", pred_taken, 0);
    upd(32'h100, 8'h00, 1'b1);
    pred(32'h100, 8'h00);
    chk("sat_lo_hold", pred_taken, 0);

    // XOR aliasing: two PC/history pairs land on idx 0, a neighbour does not
    upd(32'h4, 8'h01, 1'b1);
    pred(32'h4, 8'h01);
    chk("xor_a_idx", pred_idx, 8'h00);
    chk("xor_a_tk", pred_taken, 1);
    pred(32'h0, 8'h00);
    chk("xor_b_tk", pred_taken, 1);
    pred(32'h4, 8'h00);
    chk("xor_c_idx", pred_idx, 8'h01);
    chk("xor_c_tk", pred_taken, 0);

    // Same-index read+write: old value returned, write lands
    cyc(1'b1, 32'h100, 8'h00, 1'b1, 32'h100, 8'h00, 1'b1);
    chk("coll_tk", pred_taken, 0);
    pred(32'h100, 8'h00);
    chk("coll_after", pred_taken, 1);

    // Back-to-back trains on idx 0x41 while reading a different index
    cyc(1'b1, 32'h0, 8'h02, 1'b1, 32'h104, 8'h00, 1'b1);
    cyc(1'b1, 32'h0, 8'h03, 1'b1, 32'h104, 8'h00, 1'b1);
    upd(32'h104, 8'h00, 1'b0);
    pred(32'h104, 8'h00);
    chk("b2b_10", pred_taken, 1);
    upd(32'h104, 8'h00, 1'b0);
    pred(32'h104, 8'h00);
    chk("b2b_01", pred_taken, 0);

    // Mid-stream reset clears training
    upd(32'h100, 8'h00, 1'b1);
    pred(32'h100, 8'h00);
    chk("pre_rst_tk", pred_taken, 1);
    do_reset(1, "mid");
    pred(32'h100, 8'h00);
    chk("post_rst_tk", pred_taken, 0);

    // Streaming with concurrent training of other entries
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, $urandom, 8'((i * 37) ^ 8'h5a),
          i[0], 32'h300 + 32'(i * 4), 8'h0, i[1]);
      chk("strm_vld", pred_valid, 1);
      chk("strm_idx", pred_idx, 8'(($urandom & 0) | ((pred_pc[9:2]) ^ ghr)));
    end
    mon_e = '{pred_idx, pred_taken};
    cyc(1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 8'h0, 1'b0);
    chk("strm_end_vld", pred_valid, 0);
    chk("strm_hold_idx", pred_idx, mon_e.idx);

    repeat (2) @(posedge clk);
    #2;
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
